// File: rtl/shift_right_pipe_pkg.sv
// Shared multdiv definitions for the pipelined right shifter: stage counts,
// the per-stage pipeline record and the sign-fill mask helper.
package shift_right_pipe_pkg;

   localparam int unsigned SHIFT_STAGES = 5;
   localparam int unsigned SHAMT_W      = 5;
   localparam int unsigned MAX_W        = 64;

   // Data is carried at the widest legal width; bits at and above WIDTH stay zero.
   typedef struct packed {
      logic [MAX_W-1:0]   data;
      logic [SHAMT_W-1:0] shamt;
      logic               arith;
      logic               valid;
   } stage_rec_t;

   // Ones in bit positions [width-sh .. width-1]: where fill bits land after a right shift by sh.
   function automatic logic [MAX_W-1:0] fill_mask(input int unsigned width, input int unsigned sh);
      logic [MAX_W-1:0] ones;
      ones = (MAX_W'(1) << sh) - MAX_W'(1);
      return ones << (width - sh);
   endfunction

endpackage

// File: rtl/mux_2.sv
// Two-input multiplexer: y_c = sel ? b : a.
module mux_2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y_c
);

   assign y_c = sel ? b : a;

endmodule

// File: rtl/shift_right_stage.sv
// One pipeline stage of the right shifter: conditional shift by 2^K, then a
// register that loads only on the global advance. Sign fill needs SHIFT_RIGHT_ARITH_EN.
module shift_right_stage
   import shift_right_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned K     = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       adv,
   input  stage_rec_t d,
   output stage_rec_t q
);

   localparam int unsigned      SH   = 32'(1) << K;
   localparam logic [MAX_W-1:0] FILL = fill_mask(WIDTH, SH);

   logic             fill_c;
   logic [MAX_W-1:0] shifted_c;
   logic [MAX_W-1:0] data_c;

`ifdef SHIFT_RIGHT_ARITH_EN
   assign fill_c = d.arith & d.data[WIDTH-1];
`else
   assign fill_c = 1'b0;
`endif

   // Upper bits above WIDTH are zero, so a plain shift plus the fill mask is exact.
   assign shifted_c = (d.data >> SH) | (fill_c ? FILL : '0);

   mux_2 #(.WIDTH(MAX_W)) u_mux (
      .sel (d.shamt[K]),
      .a   (d.data),
      .b   (shifted_c),
      .y_c (data_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         q <= '0;
      end else if (adv) begin
         q.data  <= data_c;
         q.shamt <= d.shamt;
         q.arith <= d.arith;
         q.valid <= d.valid;
      end
   end

endmodule

// File: rtl/shift_right_pipe.sv
// Five-stage pipelined right barrel shifter with valid/ready on both sides.
// Define SHIFT_RIGHT_ARITH_EN to add the in_arith port (sign-fill shifts).
module shift_right_pipe
   import shift_right_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 33
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
`ifdef SHIFT_RIGHT_ARITH_EN
   input  logic               in_arith,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);

   stage_rec_t head;
   stage_rec_t pipe_q [1:SHIFT_STAGES];
   logic       adv;

   // Whole pipe moves together; a stalled output freezes every stage, bubbles included.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_comb begin
      head       = '0;
      head.data  = MAX_W'(in_data);
      head.shamt = in_shamt;
`ifdef SHIFT_RIGHT_ARITH_EN
      head.arith = in_arith;
`else
      head.arith = 1'b0;
`endif
      head.valid = in_valid;
   end

   for (genvar k = 0; k < SHIFT_STAGES; k++) begin : g_stage
      stage_rec_t d;
      if (k == 0) begin : g_head
         assign d = head;
      end else begin : g_body
         assign d = pipe_q[k];
      end

      shift_right_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
         .clock (clock),
         .reset (reset),
         .adv   (adv),
         .d     (d),
         .q     (pipe_q[k+1])
      );
   end

   assign out_valid = pipe_q[SHIFT_STAGES].valid;
   assign out_data  = pipe_q[SHIFT_STAGES].data[WIDTH-1:0];

endmodule

// File: tb/tb_shift_right_pipe.sv
// Directed self-checking bench for shift_right_pipe (WIDTH = 33); arithmetic
// cases are included when SHIFT_RIGHT_ARITH_EN is defined.
module tb_shift_right_pipe;

   localparam int unsigned W = 33;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [4:0]   in_shamt;
   logic         in_arith;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   int n_checks = 0;
   int n_fail   = 0;

   // 33'h1_0000_0080 >> s for s = 0..7, logical.
   logic [W-1:0] stbl [8] = '{33'h1_0000_0080, 33'h0_8000_0040, 33'h0_4000_0020, 33'h0_2000_0010,
                              33'h0_1000_0008, 33'h0_0800_0004, 33'h0_0400_0002, 33'h0_0200_0001};
   localparam logic [W-1:0] SDATA = 33'h1_0000_0080;

   always #5 clock = ~clock;

   shift_right_pipe #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
`ifdef SHIFT_RIGHT_ARITH_EN
      .in_arith  (in_arith),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] data, input logic [4:0] sh, input logic ar);
      in_valid = v;
      in_data  = data;
      in_shamt = sh;
      in_arith = ar;
   endtask

   // Single operand: result must appear on exactly the fifth edge counting the capture edge.
   task automatic run_one(input string tag, input logic [W-1:0] data, input logic [4:0] sh,
                          input logic ar, input logic [W-1:0] exp);
      drive(1'b1, data, sh, ar);
      step();
      drive(1'b0, '0, '0, 1'b0);
      for (int i = 1; i < 5; i++) begin
         chk({tag, "_early"}, 64'(out_valid), 64'd0);
         step();
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"}, 64'(out_data), 64'(exp));
      step();
      chk({tag, "_drain"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rx [$];
      int           leaked;

      reset     = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      step();
      step();
      reset = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      run_one("log_sh31", 33'h0_8000_0000, 5'd31, 1'b0, 33'h0_0000_0001);
      run_one("log_sh4", 33'h1_8000_0000, 5'd4, 1'b0, 33'h0_1800_0000);
      run_one("log_sh0", 33'h1_2345_6789, 5'd0, 1'b0, 33'h1_2345_6789);
      run_one("log_sh31_top", 33'h1_8000_0000, 5'd31, 1'b0, 33'h0_0000_0003);
`ifdef SHIFT_RIGHT_ARITH_EN
      run_one("ari_sh4", 33'h1_8000_0000, 5'd4, 1'b1, 33'h1_F800_0000);
      run_one("ari_sh0", 33'h1_2345_6789, 5'd0, 1'b1, 33'h1_2345_6789);
      run_one("ari_sh31", 33'h1_8000_0000, 5'd31, 1'b1, 33'h1_FFFF_FFFF);
      run_one("ari_pos", 33'h0_F000_0000, 5'd8, 1'b1, 33'h0_00F0_0000);
`endif

      // Streaming: 8 back-to-back operands, results must be contiguous and in order.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               drive(1'b1, SDATA, 5'(i), 1'b0);
               step();
            end
            drive(1'b0, '0, '0, 1'b0);
         end
         begin
            int got;
            int first;
            got   = 0;
            first = -1;
            for (int c = 0; c < 20; c++) begin
               if (out_valid) begin
                  if (first < 0) first = c;
                  chk("stream_gap", 64'(c), 64'(first + got));
                  if (got < 8) chk("stream_data", 64'(out_data), 64'(stbl[got]));
                  else chk("stream_extra", 64'(got), 64'd7);
                  got++;
               end
               step();
            end
            chk("stream_count", 64'(got), 64'd8);
         end
      join

      // Back-pressure: fill the pipe, stall 3 cycles, then drain.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, SDATA, 5'(i), 1'b0);
         step();
      end
      drive(1'b1, SDATA, 5'd5, 1'b0);
      out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(stbl[0]));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold_ready", 64'(in_ready), 64'd0);
         chk("stall_hold_valid", 64'(out_valid), 64'd1);
         chk("stall_hold_data", 64'(out_data), 64'(stbl[0]));
      end
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < 15; c++) begin
         if (out_valid && out_ready) rx.push_back(out_data);
         step();
         if (c == 0) drive(1'b0, '0, '0, 1'b0);
      end
      chk("bp_count", 64'(rx.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < rx.size()) chk("bp_order", 64'(rx[i]), 64'(stbl[i]));
      end

      // Reset with three operands in flight: none may ever emerge.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 33'h0_DEAD_BEEF, 5'(i), 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b0);
      reset = 1'b1;
      step();
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_data", 64'(out_data), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      reset  = 1'b0;
      leaked = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (out_valid) leaked++;
      end
      chk("midrst_leak", 64'(leaked), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
